// File: rtl/pwm_gen.sv
// Audio PWM output stage: 8-bit sample to 1-bit duty over a 2**WIDTH frame.
// Counter runs while enabled; output is a live compare against the sample.
module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] mixed_sample,
  input  logic             enable,
  output logic             PWM_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             below;

  // next count: advance and wrap while enabled, freeze otherwise
  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // frame counter, cleared asynchronously
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // unregistered duty compare; reset and enable force the pin low
  always_comb begin
    below = (count_q < mixed_sample);
    PWM_o = nrst & enable & below;
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: directed frame checks plus randomized run
// against a frame-position model.
`timescale 1ns/100ps
module tb_pwm_gen;

  localparam int W = 8;
  localparam int FRAME = 1 << W;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [W-1:0] mixed_sample = '0;
  logic         enable = 1'b0;
  logic         PWM_o;

  int vectors = 0;
  int miscompares = 0;
  int pos = 0;

  pwm_gen #(.WIDTH(W)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .mixed_sample (mixed_sample),
    .enable       (enable),
    .PWM_o        (PWM_o)
  );

  always #50 clk = ~clk;

  // frame position: clocks spent enabled since reset, modulo frame length
  always @(posedge clk or negedge nrst) begin
    if (!nrst) pos = 0;
    else if (enable) pos = (pos + 1) % FRAME;
  end

  function automatic logic model_out();
    return nrst && enable && (pos < int'(mixed_sample));
  endfunction

  task automatic chk(input string name, input logic got,
                     input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: PWM_o=%b expected %b (t=%0t)",
               name, got, exp, $time);
    end
  endtask

  // continuous comparison against the model
  always @(negedge clk) begin
    #2;
    chk("model", PWM_o, model_out());
  end

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_to(inout int cyc, input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic frame_test(input string name, input logic [W-1:0] s,
                            input logic [5:0] e);
    int cyc;
    do_reset();
    mixed_sample = s;
    enable = 1'b1;
    cyc = 0;
    wait_to(cyc, 1);   chk({name, "@1"},   PWM_o, e[5]);
    wait_to(cyc, 126); chk({name, "@126"}, PWM_o, e[4]);
    wait_to(cyc, 127); chk({name, "@127"}, PWM_o, e[3]);
    wait_to(cyc, 128); chk({name, "@128"}, PWM_o, e[2]);
    wait_to(cyc, 255); chk({name, "@255"}, PWM_o, e[1]);
    wait_to(cyc, 256); chk({name, "@256"}, PWM_o, e[0]);
  endtask

  initial begin
    int cyc;
    // power-on reset
    #40;
    chk("por_half", PWM_o, 1'b0);
    #100;
    chk("por_full", PWM_o, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    #1.1;
    chk("por_release", PWM_o, 1'b0);

    frame_test("half", 8'd127, 6'b110001);
    frame_test("off",  8'd0,   6'b000000);
    frame_test("full", 8'd255, 6'b111101);

    // enable gating
    do_reset();
    mixed_sample = 8'd127;
    enable = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk("gate_run", PWM_o, 1'b1);
    enable = 1'b0;
    #1;
    chk("gate_off_now", PWM_o, 1'b0);
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("gate_off", PWM_o, 1'b0);
    end
    enable = 1'b1;
    #1;
    chk("gate_resume", PWM_o, 1'b1);
    repeat (76) @(negedge clk);
    #1;
    chk("gate_76", PWM_o, 1'b1);
    @(negedge clk);
    #1;
    chk("gate_77", PWM_o, 1'b0);

    // mid-run reset
    do_reset();
    mixed_sample = 8'd200;
    enable = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("mid_pre", PWM_o, 1'b1);
    nrst = 1'b0;
    #1;
    chk("mid_rst", PWM_o, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_held", PWM_o, 1'b0);
    nrst = 1'b1;
    cyc = 0;
    wait_to(cyc, 1);   chk("mid@1",   PWM_o, 1'b1);
    wait_to(cyc, 199); chk("mid@199", PWM_o, 1'b1);
    wait_to(cyc, 200); chk("mid@200", PWM_o, 1'b0);

    // randomized run: live sample changes, enable gaps, resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!nrst) nrst = 1'b1;
      else if ($urandom_range(0, 499) == 0) nrst = 1'b0;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) mixed_sample = W'($urandom);
    end

    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
